// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: loader write port, execute redirect, decode handshake and fault status.
// master drives stimulus/consumes instructions; slave is the fetch unit.
interface fetch_queue_if #(
    parameter int unsigned XLEN                = 32,
    parameter int unsigned PROGRAM_MEMORY_SIZE = 64,
    parameter int unsigned QUEUE_DEPTH         = 2
);
    localparam int unsigned AW = $clog2(PROGRAM_MEMORY_SIZE);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

    logic            imem_we;
    logic [AW-1:0]   imem_waddr;
    logic [31:0]     imem_wdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_next;
    logic [CW-1:0]   queue_count;
    logic            fault;
    logic [XLEN-1:0] fault_pc;

    modport master (
        output imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, out_ready,
        input  out_valid, out_instr, out_pc, out_pc_next, queue_count, fault, fault_pc
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, out_ready,
        output out_valid, out_instr, out_pc, out_pc_next, queue_count, fault, fault_pc
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the PC, reads program memory, resolves JAL in fetch and
// buffers {pc, instr} pairs in a small FIFO toward decode.
module fetch_queue_unit #(
    parameter int unsigned     XLEN                = 32,
    parameter int unsigned     PROGRAM_MEMORY_SIZE = 64,
    parameter int unsigned     QUEUE_DEPTH         = 2,
    parameter logic [XLEN-1:0] RESET_PC            = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.slave bus
);
    localparam int unsigned AW     = $clog2(PROGRAM_MEMORY_SIZE);
    localparam int unsigned PW     = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW     = PW + 1;
    localparam logic [6:0]  OP_JAL = 7'b1101111;

    logic [31:0]     mem     [PROGRAM_MEMORY_SIZE];
    logic [XLEN-1:0] q_pc    [QUEUE_DEPTH];
    logic [31:0]     q_instr [QUEUE_DEPTH];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    logic [XLEN-1:0] word_idx;
    logic            in_range;
    logic [31:0]     fetch_instr;
    logic [XLEN-1:0] jal_imm;
    logic [XLEN-1:0] next_pc;
    logic            out_valid;
    logic            pop;
    logic            has_space;
    logic            fetch_en;
    logic            push;
    logic            fetch_fault;
    logic            redirect_misaligned;

    // Combinational memory read; out-of-range reads return zero and raise a fault instead.
    assign word_idx    = pc_q >> 2;
    assign in_range    = word_idx < XLEN'(PROGRAM_MEMORY_SIZE);
    assign fetch_instr = in_range ? mem[word_idx[AW-1:0]] : 32'h0;

    assign jal_imm = {{(XLEN-20){fetch_instr[31]}}, fetch_instr[19:12], fetch_instr[20],
                      fetch_instr[30:21], 1'b0};
    assign next_pc = (fetch_instr[6:0] == OP_JAL) ? pc_q + jal_imm : pc_q + XLEN'(4);

    assign out_valid           = count_q != '0;
    assign pop                 = out_valid & bus.out_ready;
    assign has_space           = (count_q < CW'(QUEUE_DEPTH)) | pop;
    assign fetch_en            = ~fault_q & ~bus.redirect_valid & has_space;
    assign push                = fetch_en & in_range;
    assign fetch_fault         = fetch_en & ~in_range;
    assign redirect_misaligned = bus.redirect_pc[1:0] != 2'b00;

    always_comb begin
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (bus.redirect_valid) begin
            // Flush wins over any same-cycle pop; the queue simply empties.
            pc_d     = bus.redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (redirect_misaligned && !fault_q) begin
                fault_d    = 1'b1;
                fault_pc_d = bus.redirect_pc;
            end
        end else begin
            if (push) begin
                pc_d     = next_pc;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (fetch_fault) begin
                fault_d    = 1'b1;
                fault_pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // Entry storage needs no reset: it is only visible through out_valid-gated outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_q]    <= pc_q;
            q_instr[wr_ptr_q] <= fetch_instr;
        end
    end

    // Loader port; a same-cycle fetch of this word still sees the old contents.
    always_ff @(posedge clk) begin
        if (bus.imem_we && (32'(bus.imem_waddr) < 32'(PROGRAM_MEMORY_SIZE))) begin
            mem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.out_instr   = out_valid ? q_instr[rd_ptr_q] : 32'h0;
    assign bus.out_pc      = out_valid ? q_pc[rd_ptr_q] : '0;
    assign bus.out_pc_next = out_valid ? q_pc[rd_ptr_q] + XLEN'(4) : '0;
    assign bus.queue_count = count_q;
    assign bus.fault       = fault_q;
    assign bus.fault_pc    = fault_pc_q;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a 64-word instance for fetch/JAL/back-pressure/redirect
// and a 4-word instance for the end-of-memory fault.
module tb_fetch_queue_unit;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JAL_P8 = 32'h0080_006F;
    localparam logic [31:0] JAL_M4 = 32'hFFDF_F06F;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_a [64];
    logic [31:0] m_b [4];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32), .PROGRAM_MEMORY_SIZE(64), .QUEUE_DEPTH(2)) if_a ();
    fetch_queue_if #(.XLEN(32), .PROGRAM_MEMORY_SIZE(4), .QUEUE_DEPTH(2)) if_b ();

    fetch_queue_unit #(
        .XLEN(32), .PROGRAM_MEMORY_SIZE(64), .QUEUE_DEPTH(2), .RESET_PC(32'h0)
    ) dut_a (
        .clk(clk), .reset(rst_a), .bus(if_a)
    );

    fetch_queue_unit #(
        .XLEN(32), .PROGRAM_MEMORY_SIZE(4), .QUEUE_DEPTH(2), .RESET_PC(32'h0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .bus(if_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int addr, input logic [31:0] d);
        if_a.imem_we    = 1'b1;
        if_a.imem_waddr = 6'(addr);
        if_a.imem_wdata = d;
        m_a[addr]       = d;
        tick();
        if_a.imem_we = 1'b0;
    endtask

    task automatic load_b(input int addr, input logic [31:0] d);
        if_b.imem_we    = 1'b1;
        if_b.imem_waddr = 2'(addr);
        if_b.imem_wdata = d;
        m_b[addr]       = d;
        tick();
        if_b.imem_we = 1'b0;
    endtask

    task automatic pop_check_a(input string tag);
        logic [31:0] pc;
        check({tag, "_pending"}, 64'(exp_a.size() != 0), 64'd1);
        if (exp_a.size() != 0) begin
            pc = exp_a.pop_front();
            check({tag, "_valid"}, 64'(if_a.out_valid), 64'd1);
            check({tag, "_pc"}, 64'(if_a.out_pc), 64'(pc));
            check({tag, "_instr"}, 64'(if_a.out_instr), 64'(m_a[pc[7:2]]));
            check({tag, "_pc_next"}, 64'(if_a.out_pc_next), 64'(pc + 32'd4));
        end
    endtask

    task automatic pop_check_b(input string tag);
        logic [31:0] pc;
        check({tag, "_pending"}, 64'(exp_b.size() != 0), 64'd1);
        if (exp_b.size() != 0) begin
            pc = exp_b.pop_front();
            check({tag, "_valid"}, 64'(if_b.out_valid), 64'd1);
            check({tag, "_pc"}, 64'(if_b.out_pc), 64'(pc));
            check({tag, "_instr"}, 64'(if_b.out_instr), 64'(m_b[pc[3:2]]));
        end
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_valid"}, 64'(if_a.out_valid), 64'd0);
        check({tag, "_count"}, 64'(if_a.queue_count), 64'd0);
        check({tag, "_instr"}, 64'(if_a.out_instr), 64'd0);
        check({tag, "_pc"}, 64'(if_a.out_pc), 64'd0);
        check({tag, "_pc_next"}, 64'(if_a.out_pc_next), 64'd0);
        check({tag, "_fault"}, 64'(if_a.fault), 64'd0);
        check({tag, "_fault_pc"}, 64'(if_a.fault_pc), 64'd0);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        if_a.imem_we = 1'b0; if_a.imem_waddr = '0; if_a.imem_wdata = '0;
        if_a.redirect_valid = 1'b0; if_a.redirect_pc = '0; if_a.out_ready = 1'b0;
        if_b.imem_we = 1'b0; if_b.imem_waddr = '0; if_b.imem_wdata = '0;
        if_b.redirect_valid = 1'b0; if_b.redirect_pc = '0; if_b.out_ready = 1'b0;
        tick();
        check_zero_a("reset");

        // Straight-line NOPs at full throughput.
        for (int i = 0; i < 64; i++) load_a(i, NOP);
        if_a.out_ready = 1'b1;
        rst_a = 1'b1;
        for (int i = 0; i < 4; i++) exp_a.push_back(32'(4 * i));
        for (int i = 0; i < 4; i++) begin
            tick();
            pop_check_a("seq");
            check("seq_count", 64'(if_a.queue_count), 64'd1);
        end

        // JAL +8 at 4, JAL -4 at 16: no bubbles.
        rst_a = 1'b0;
        exp_a.delete();
        load_a(1, JAL_P8);
        load_a(4, JAL_M4);
        rst_a = 1'b1;
        exp_a.push_back(32'h0);  exp_a.push_back(32'h4);  exp_a.push_back(32'hC);
        exp_a.push_back(32'h10); exp_a.push_back(32'hC);  exp_a.push_back(32'h10);
        for (int i = 0; i < 6; i++) begin
            tick();
            pop_check_a("jal");
        end

        // Back-pressure: queue fills to 2 and holds, then drains with push+pop each cycle.
        rst_a = 1'b0;
        exp_a.delete();
        load_a(1, NOP);
        load_a(4, NOP);
        if_a.out_ready = 1'b0;
        rst_a = 1'b1;
        tick();
        check("bp_count1", 64'(if_a.queue_count), 64'd1);
        tick();
        check("bp_count2", 64'(if_a.queue_count), 64'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_sat", 64'(if_a.queue_count), 64'd2);
            check("bp_head", 64'(if_a.out_pc), 64'd0);
        end
        exp_a.push_back(32'h0);
        pop_check_a("bp_pre");
        for (int i = 1; i < 5; i++) exp_a.push_back(32'(4 * i));
        if_a.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            pop_check_a("drain");
            check("drain_count", 64'(if_a.queue_count), 64'd2);
        end

        // Redirect while full flushes, target shows up two edges later.
        if_a.redirect_valid = 1'b1;
        if_a.redirect_pc    = 32'h20;
        tick();
        if_a.redirect_valid = 1'b0;
        check("redir_bubble_valid", 64'(if_a.out_valid), 64'd0);
        check("redir_bubble_count", 64'(if_a.queue_count), 64'd0);
        exp_a.delete();
        exp_a.push_back(32'h20);
        exp_a.push_back(32'h24);
        tick();
        pop_check_a("redir");
        tick();
        pop_check_a("redir");

        // Misaligned redirect faults; a later aligned redirect neither clears nor resumes.
        if_a.redirect_valid = 1'b1;
        if_a.redirect_pc    = 32'h22;
        tick();
        if_a.redirect_valid = 1'b0;
        check("mis_fault", 64'(if_a.fault), 64'd1);
        check("mis_fault_pc", 64'(if_a.fault_pc), 64'h22);
        check("mis_valid", 64'(if_a.out_valid), 64'd0);
        tick();
        tick();
        check("mis_stop_valid", 64'(if_a.out_valid), 64'd0);
        check("mis_stop_count", 64'(if_a.queue_count), 64'd0);
        if_a.redirect_valid = 1'b1;
        if_a.redirect_pc    = 32'h0;
        tick();
        if_a.redirect_valid = 1'b0;
        tick();
        check("sticky_fault", 64'(if_a.fault), 64'd1);
        check("sticky_fault_pc", 64'(if_a.fault_pc), 64'h22);
        check("sticky_valid", 64'(if_a.out_valid), 64'd0);

        // Small memory: running off the end faults at pc 16 after the last word drains.
        for (int i = 0; i < 4; i++) load_b(i, NOP);
        if_b.out_ready = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) exp_b.push_back(32'(4 * i));
        for (int i = 0; i < 4; i++) begin
            tick();
            pop_check_b("end");
            check("end_nofault", 64'(if_b.fault), 64'd0);
        end
        tick();
        check("end_fault", 64'(if_b.fault), 64'd1);
        check("end_fault_pc", 64'(if_b.fault_pc), 64'h10);
        check("end_valid", 64'(if_b.out_valid), 64'd0);
        tick();
        check("end_stop_count", 64'(if_b.queue_count), 64'd0);

        // Reset clears the fault; mid-stream async reset zeroes outputs without a clock edge.
        rst_a = 1'b0;
        #1;
        rst_a = 1'b1;
        exp_a.delete();
        exp_a.push_back(32'h0);
        exp_a.push_back(32'h4);
        tick();
        check("rst_fault_clear", 64'(if_a.fault), 64'd0);
        pop_check_a("pre_rst");
        tick();
        pop_check_a("pre_rst");
        #3;
        rst_a = 1'b0;
        #1;
        check_zero_a("async_rst");
        rst_a = 1'b1;
        exp_a.delete();
        exp_a.push_back(32'h0);
        exp_a.push_back(32'h4);
        tick();
        pop_check_a("restart");
        tick();
        pop_check_a("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch stage that owns the program counter, reads the word-addressed program memory, resolves JAL targets in fetch, and buffers fetched instructions in a small FIFO toward decode with a valid/ready handshake. It sits between the program memory and the single-instruction datapath. It generalises the fixed PC/PC+4/JAL mux with configurable width, memory depth and queue depth, execute-stage redirects, back-pressure and fault detection.

## Interface
- XLEN, 32, PC and instruction-address width
- PROGRAM_MEMORY_SIZE, 64, program memory depth in 32-bit words
- QUEUE_DEPTH, 2, fetch FIFO entries; power of two, at least 2
- RESET_PC, 0, PC value loaded on reset; word-aligned
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- imem_we  input  1  program memory write strobe (loader port)
- imem_waddr  input  $clog2(PROGRAM_MEMORY_SIZE)  word address to write
- imem_wdata  input  32  word to write
- redirect_valid  input  1  execute-stage taken branch/JALR
- redirect_pc  input  XLEN  redirect target
- out_valid  output  1  queue head holds an instruction
- out_ready  input  1  decode accepts head this cycle
- out_instr  output  32  head instruction word
- out_pc  output  XLEN  head instruction address
- out_pc_next  output  XLEN  out_pc + 4 (link value)
- queue_count  output  $clog2(QUEUE_DEPTH)+1  occupied entries
- fault  output  1  sticky fetch fault
- fault_pc  output  XLEN  PC that caused the fault

## Operation
- Reset (reset low): pc = RESET_PC, queue empty, out_valid = 0, queue_count = 0, fault = 0, fault_pc = 0; out_instr/out_pc/out_pc_next = 0. Memory contents are not cleared.
- Fetch enable: not faulted, no redirect this cycle, and (queue_count < QUEUE_DEPTH or head popped this cycle).
- When enabled: instr = mem[pc >> 2]; push {pc, instr}. Next pc:
  - opcode instr[6:0] == 7'b1101111 (JAL): pc + sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), XLEN modular.
  - Otherwise: pc + 4, wrapping modulo 2^XLEN.
- When not enabled due to a full queue, pc holds.
- Pop occurs when out_valid && out_ready. Push and pop may occur in the same cycle; queue_count is unchanged.
- Redirect has top priority. Queue is flushed and the same-cycle pop is discarded. pc <= redirect_pc. No push in that cycle.
- Faults: a fetch with (pc >> 2) >= PROGRAM_MEMORY_SIZE, or a redirect with redirect_pc[1:0] != 0, sets fault and captures fault_pc.
  - After a fault, fetch stops. Queued entries still drain.
  - Only reset clears fault. A later redirect does not.
- imem write: mem[imem_waddr] <= imem_wdata at the clock edge. A fetch reading the same address in the same cycle returns the old word.

## Timing
- Memory read is combinational. Queue and pc are registered.
- Fetch-to-out_valid latency is 1 cycle. The first instruction after reset deassertion is valid after the first rising edge.
- Sustained throughput is 1 instruction/cycle when out_ready = 1.
- JAL costs no bubble: the target is fetched the cycle after the JAL.
- Redirect: out_valid = 0 in the cycle after the redirect edge. The target instruction appears 2 edges after redirect sampling.
- Outputs hold stable while out_valid && !out_ready.
- An asynchronous reset assertion mid-stream clears the queue and outputs without waiting for clk.

## Test plan
- Reset, memory[0..3] = NOPs 0x00000013, out_ready = 1 -> out_pc = 0, 4, 8, 12 on consecutive cycles; out_pc_next = out_pc + 4.
- mem[1] = 0x0080006F (JAL +8) -> sequence out_pc = 0, 4, 12, 16; no bubble. mem[4] = 0xFFDFF06F (JAL -4) -> next out_pc = 12.
- out_ready = 0 for 5 cycles -> queue_count saturates at QUEUE_DEPTH, pc holds, head unchanged. Release -> in-order drain with no loss or duplicate.
- Full queue with pop and push in the same cycle -> queue_count stays 2 and order is preserved.
- redirect_valid with redirect_pc = 0x20 while queue is full -> next cycle out_valid = 0, then out_pc = 0x20. redirect_pc = 0x22 -> fault = 1, fault_pc = 0x22, no further fetches.
- PROGRAM_MEMORY_SIZE = 4, straight-line code -> after pc 12, fault = 1 with fault_pc = 16. Reset pulse mid-stream -> all outputs zero immediately, and fetch restarts at RESET_PC.
